// File: rtl/m72_irq_pkg.sv
// m72_irq_pkg: shared constants and helpers for the M72 priority interrupt
// controller.
//   - register address map (IMR, VBASE, IRR/EOI, ISR/CTRL)
//   - EOI command and CTRL bit positions
//   - prio_enc(): lowest-index-first priority encoder, returns {found, index}
package m72_irq_pkg;

   localparam logic [1:0] REG_IMR      = 2'd0;
   localparam logic [1:0] REG_VBASE    = 2'd1;
   localparam logic [1:0] REG_IRR_EOI  = 2'd2;
   localparam logic [1:0] REG_ISR_CTRL = 2'd3;

   // EOI command: bit 7 selects specific EOI, bits 2:0 carry the channel
   localparam int EOI_SPEC_BIT  = 7;
   localparam int EOI_IDX_MSB   = 2;
   localparam int EOI_IDX_LSB   = 0;
   localparam int CTRL_AEOI_BIT = 0;

   // Scans from the top down so the last hit, i.e. the lowest set index, wins.
   function automatic logic [3:0] prio_enc(input logic [7:0] vec);
      logic [3:0] res;
      res = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (vec[i]) begin
            res = {1'b1, 3'(i)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/m72_irq_ctrl_if.sv
// m72_irq_ctrl_if: CPU-side bus of the M72 interrupt controller.
//   cs/wr/addr/din/dout : register access (dout is combinational from addr)
//   int_rq              : interrupt request to the CPU
//   int_ack             : CPU acknowledge, level, high for the whole ack cycle
//   int_vec/vec_valid   : vector presented during the acknowledge
// master = CPU side, slave = controller side.
interface m72_irq_ctrl_if;
   logic       cs;
   logic       wr;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       int_rq;
   logic       int_ack;
   logic [7:0] int_vec;
   logic       vec_valid;

   modport master (
      output cs, wr, addr, din, int_ack,
      input  dout, int_rq, int_vec, vec_valid
   );

   modport slave (
      input  cs, wr, addr, din, int_ack,
      output dout, int_rq, int_vec, vec_valid
   );
endinterface

// File: rtl/m72_prio_enc.sv
// m72_prio_enc: parametrised lowest-index-first priority encoder.
//   vec   in  N  request vector (bit 0 = highest priority)
//   found out 1  any bit set
//   idx   out 3  index of the lowest set bit (0 when nothing is set)
module m72_prio_enc
   import m72_irq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] vec,
   output logic         found,
   output logic [2:0]   idx
);

   logic [7:0] vec_w;

   // Widen to the helper's fixed 8-bit input and encode.
   always_comb begin
      vec_w         = 8'd0;
      vec_w[N-1:0]  = vec;
      {found, idx}  = prio_enc(vec_w);
   end

endmodule

// File: rtl/m72_irq_ctrl.sv
// m72_irq_ctrl: uPD71059-style priority interrupt controller for the M72 CPU.
//   CLK_32M   in   system clock
//   reset     in   asynchronous active-high reset
//   bus       slave modport of m72_irq_ctrl_if (register access + int/ack)
//   irq_in    in   NUM_IRQ request lines, synchronous to CLK_32M
//   isr       out  NUM_IRQ in-service register (status)
// Channel 0 has the highest priority; nesting is fully nested.
module m72_irq_ctrl
   import m72_irq_pkg::*;
#(
   parameter int         NUM_IRQ      = 8,
   parameter logic [7:0] VEC_BASE_RST = 8'h20,
   parameter logic [7:0] MASK_RST     = 8'h00,
   parameter logic [7:0] LEVEL_MASK   = 8'h00
) (
   input  logic               CLK_32M,
   input  logic               reset,
   m72_irq_ctrl_if.slave      bus,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic [NUM_IRQ-1:0] isr
);

   localparam logic [NUM_IRQ-1:0] LVL      = LEVEL_MASK[NUM_IRQ-1:0];
   localparam logic [NUM_IRQ-1:0] IMR_INIT = MASK_RST[NUM_IRQ-1:0];
   localparam logic [7:0]         SPUR_OFS = 8'(NUM_IRQ - 1);

   logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, irq_q, irq_d;
   logic [7:0]         vbase_q, vbase_d, vec_q, vec_d;
   logic               aeoi_q, aeoi_d, ack_q, ack_d;
   logic               int_rq_q, int_rq_d, vld_q, vld_d;

   logic [NUM_IRQ-1:0] pend_s;
   logic               win_found_s, top_found_s, qual_s, ack_trig_s, reg_wr_s;
   logic [2:0]         win_idx_s, top_idx_s, eoi_idx_s;

   assign pend_s = irr_q & ~imr_q;

   m72_prio_enc #(.N(NUM_IRQ)) u_enc_pend (
      .vec   (pend_s),
      .found (win_found_s),
      .idx   (win_idx_s)
   );

   m72_prio_enc #(.N(NUM_IRQ)) u_enc_isr (
      .vec   (isr_q),
      .found (top_found_s),
      .idx   (top_idx_s)
   );

   // Next-state logic: register writes, EOI, acknowledge capture, request capture.
   always_comb begin
      irr_d    = irr_q;
      isr_d    = isr_q;
      imr_d    = imr_q;
      vbase_d  = vbase_q;
      aeoi_d   = aeoi_q;
      vec_d    = vec_q;
      irq_d    = irq_in;
      ack_d    = bus.int_ack;
      int_rq_d = 1'b0;
      vld_d    = 1'b0;

      reg_wr_s   = bus.cs & bus.wr;
      ack_trig_s = bus.int_ack & ~ack_q;
      eoi_idx_s  = bus.din[EOI_IDX_MSB:EOI_IDX_LSB];
      // A pending request only qualifies if nothing of higher or equal
      // priority is already in service.
      qual_s     = win_found_s & (~top_found_s | (win_idx_s < top_idx_s));

      if (reg_wr_s) begin
         case (bus.addr)
            REG_IMR:      imr_d   = bus.din[NUM_IRQ-1:0];
            REG_VBASE:    vbase_d = bus.din;
            REG_IRR_EOI: begin
               if (bus.din[EOI_SPEC_BIT]) begin
                  if (int'(eoi_idx_s) < NUM_IRQ) begin
                     isr_d[eoi_idx_s] = 1'b0;
                  end else begin
                     isr_d = isr_d;
                  end
               end else if (top_found_s) begin
                  isr_d[top_idx_s] = 1'b0;
               end else begin
                  isr_d = isr_d;
               end
            end
            REG_ISR_CTRL: aeoi_d  = bus.din[CTRL_AEOI_BIT];
            default:      imr_d   = imr_q;
         endcase
      end else begin
         imr_d = imr_q;
      end

      // The ack set is applied after the EOI clear so that it wins on a tie.
      // int_rq is dropped for the capture cycle and re-evaluated afterwards.
      if (ack_trig_s) begin
         vld_d = 1'b1;
         if (qual_s) begin
            vec_d            = vbase_q + {5'd0, win_idx_s};
            irr_d[win_idx_s] = 1'b0;
            if (!aeoi_q) begin
               isr_d[win_idx_s] = 1'b1;
            end else begin
               isr_d = isr_d;
            end
         end else begin
            vec_d = vbase_q + SPUR_OFS;
         end
      end else begin
         int_rq_d = qual_s;
         vld_d    = vld_q & bus.int_ack;
      end

      // Capture runs last so a new request beats the ack clear.
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (LVL[i]) begin
            irr_d[i] = irq_in[i];
         end else if (irq_in[i] & ~irq_q[i]) begin
            irr_d[i] = 1'b1;
         end else begin
            irr_d[i] = irr_d[i];
         end
      end
   end

   // State registers.
   always_ff @(posedge CLK_32M or posedge reset) begin
      if (reset) begin
         irr_q    <= '0;
         isr_q    <= '0;
         imr_q    <= IMR_INIT;
         vbase_q  <= VEC_BASE_RST;
         aeoi_q   <= 1'b0;
         irq_q    <= '0;
         ack_q    <= 1'b0;
         vec_q    <= 8'h00;
         int_rq_q <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         irr_q    <= irr_d;
         isr_q    <= isr_d;
         imr_q    <= imr_d;
         vbase_q  <= vbase_d;
         aeoi_q   <= aeoi_d;
         irq_q    <= irq_d;
         ack_q    <= ack_d;
         vec_q    <= vec_d;
         int_rq_q <= int_rq_d;
         vld_q    <= vld_d;
      end
   end

   // Read mux, combinational from addr; unused high bits read 0.
   always_comb begin
      bus.dout = 8'h00;
      case (bus.addr)
         REG_IMR:      bus.dout[NUM_IRQ-1:0] = imr_q;
         REG_VBASE:    bus.dout              = vbase_q;
         REG_IRR_EOI:  bus.dout[NUM_IRQ-1:0] = irr_q;
         REG_ISR_CTRL: bus.dout[NUM_IRQ-1:0] = isr_q;
         default:      bus.dout              = 8'h00;
      endcase
   end

   assign bus.int_rq  = int_rq_q;
   assign bus.int_vec = vec_q;
   // Gated with int_ack so the vector window closes as soon as the ack ends.
   assign bus.vec_valid = vld_q & bus.int_ack;
   assign isr = isr_q;

endmodule

// File: tb/tb_m72_irq_ctrl.sv
// tb_m72_irq_ctrl: self-checking bench for m72_irq_ctrl.
// Register table, hand-written acknowledge/EOI sequences, then randomized
// traffic compared against a bit-level reference model. Channel 7 is level.
module tb_m72_irq_ctrl;

   logic       clk;
   logic       reset;
   logic [7:0] irq_in;
   logic [7:0] isr;
   int         checks;
   int         failures;

   m72_irq_ctrl_if bif ();

   m72_irq_ctrl #(
      .NUM_IRQ      (8),
      .VEC_BASE_RST (8'h20),
      .MASK_RST     (8'h00),
      .LEVEL_MASK   (8'h80)
   ) dut (
      .CLK_32M (clk),
      .reset   (reset),
      .bus     (bif),
      .irq_in  (irq_in),
      .isr     (isr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         do_wr;
      logic [1:0] waddr;
      logic [7:0] wdata;
      logic [1:0] raddr;
      logic [7:0] exp;
   } reg_vec_t;

   reg_vec_t tbl [10];

   // reference model state
   logic [7:0] m_irr, m_isr, m_imr, m_vbase, m_vec, m_pirq;
   bit         m_aeoi, m_pack, m_rq, m_arm;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      bif.cs = 1'b1; bif.wr = 1'b1; bif.addr = a; bif.din = d;
      tick();
      bif.cs = 1'b0; bif.wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
      bif.addr = a;
      #1;
      d = bif.dout;
   endtask

   task automatic pulse(input int ch);
      irq_in[ch] = 1'b1;
      tick();
      irq_in[ch] = 1'b0;
   endtask

   // Holds int_ack for n cycles (n >= 2); reports last vector and valid count.
   task automatic do_ack(input int n, output logic [7:0] vec, output int vcnt);
      vcnt = 0;
      vec  = 8'h00;
      bif.int_ack = 1'b1;
      tick();
      for (int k = 1; k < n; k++) begin
         if (bif.vec_valid) vcnt++;
         vec = bif.int_vec;
         tick();
      end
      bif.int_ack = 1'b0;
      #1;
      chk("valid_drop", bif.vec_valid, 1'b0);
      tick();
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_vbase = 8'h20;
      m_vec = 8'h00; m_pirq = 8'h00; m_aeoi = 1'b0; m_pack = 1'b0;
      m_rq = 1'b0; m_arm = 1'b0;
   endtask

   // One clock of the reference model, from the inputs currently applied.
   task automatic model_step();
      int         w, t, e;
      bit         qual, trig, wr;
      logic [7:0] nirr, nisr;
      w    = lowest(m_irr & ~m_imr);
      t    = lowest(m_isr);
      qual = (w >= 0) && (t < 0 || w < t);
      trig = bif.int_ack && !m_pack;
      wr   = bif.cs && bif.wr;
      nirr = m_irr;
      nisr = m_isr;
      if (wr && bif.addr == 2'd2) begin
         e = bif.din[7] ? int'(bif.din[2:0]) : t;
         if (e >= 0) nisr[e] = 1'b0;
      end
      if (trig) begin
         m_rq  = 1'b0;
         m_arm = 1'b1;
         if (qual) begin
            m_vec   = 8'((int'(m_vbase) + w) % 256);
            nirr[w] = 1'b0;
            if (!m_aeoi) nisr[w] = 1'b1;
         end else begin
            m_vec = 8'((int'(m_vbase) + 7) % 256);
         end
      end else begin
         m_rq  = qual;
         m_arm = m_arm && bif.int_ack;
      end
      for (int i = 0; i < 7; i++) if (irq_in[i] && !m_pirq[i]) nirr[i] = 1'b1;
      nirr[7] = irq_in[7];
      if (wr && bif.addr == 2'd0) m_imr = bif.din;
      if (wr && bif.addr == 2'd1) m_vbase = bif.din;
      if (wr && bif.addr == 2'd3) m_aeoi = bif.din[0];
      m_irr  = nirr;
      m_isr  = nisr;
      m_pirq = irq_in;
      m_pack = bif.int_ack;
   endtask

   initial begin
      logic [7:0] rd, vec, exp_dout;
      int         vcnt;
      checks = 0; failures = 0;
      reset = 1'b1; irq_in = 8'h00;
      bif.cs = 1'b0; bif.wr = 1'b0; bif.addr = 2'd0; bif.din = 8'h00; bif.int_ack = 1'b0;

      tbl[0] = '{1'b0, 2'd0, 8'h00, 2'd1, 8'h20};
      tbl[1] = '{1'b0, 2'd0, 8'h00, 2'd0, 8'h00};
      tbl[2] = '{1'b0, 2'd0, 8'h00, 2'd2, 8'h00};
      tbl[3] = '{1'b0, 2'd0, 8'h00, 2'd3, 8'h00};
      tbl[4] = '{1'b1, 2'd0, 8'hA5, 2'd0, 8'hA5};
      tbl[5] = '{1'b1, 2'd1, 8'h3C, 2'd1, 8'h3C};
      tbl[6] = '{1'b1, 2'd2, 8'h00, 2'd3, 8'h00};
      tbl[7] = '{1'b1, 2'd3, 8'h00, 2'd2, 8'h00};
      tbl[8] = '{1'b1, 2'd0, 8'h00, 2'd0, 8'h00};
      tbl[9] = '{1'b1, 2'd1, 8'h20, 2'd1, 8'h20};

      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_int_rq", bif.int_rq, 1'b0);
      chk("rst_vec_valid", bif.vec_valid, 1'b0);
      chk("rst_int_vec", bif.int_vec, 8'h00);
      chk("rst_isr", isr, 8'h00);

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].do_wr) wr_reg(tbl[i].waddr, tbl[i].wdata);
         rd_reg(tbl[i].raddr, rd);
         chk($sformatf("table_%0d", i), rd, tbl[i].exp);
      end

      // IR0 edge, then a 4-cycle acknowledge
      pulse(0);
      chk("ir0_rq_early", bif.int_rq, 1'b0);
      tick();
      chk("ir0_rq", bif.int_rq, 1'b1);
      do_ack(4, vec, vcnt);
      chk("ir0_vec", vec, 8'h20);
      chk("ir0_valid_cycles", vcnt, 3);
      chk("ir0_isr", isr, 8'h01);
      chk("ir0_rq_after", bif.int_rq, 1'b0);

      // IR2 blocked by IR0 in service, released by non-specific EOI
      pulse(2); tick(); tick();
      chk("ir2_blocked", bif.int_rq, 1'b0);
      wr_reg(2'd2, 8'h00);
      tick();
      chk("nseoi_isr", isr, 8'h00);
      chk("nseoi_rq", bif.int_rq, 1'b1);
      do_ack(3, vec, vcnt);
      chk("ir2_vec", vec, 8'h22);
      chk("ir2_isr", isr, 8'h04);

      // IR0 nests above IR2; specific EOI for channel 2
      pulse(0); tick();
      chk("nest_rq", bif.int_rq, 1'b1);
      do_ack(3, vec, vcnt);
      chk("nest_vec", vec, 8'h20);
      chk("nest_isr", isr, 8'h05);
      wr_reg(2'd2, 8'h82); tick();
      chk("seoi_isr", isr, 8'h01);
      wr_reg(2'd2, 8'h80); tick();
      chk("seoi0_isr", isr, 8'h00);

      // Masked capture
      wr_reg(2'd0, 8'hFF);
      pulse(3); tick();
      rd_reg(2'd2, rd);
      chk("mask_irr", rd, 8'h08);
      chk("mask_rq", bif.int_rq, 1'b0);
      wr_reg(2'd0, 8'h00); tick();
      chk("unmask_rq", bif.int_rq, 1'b1);
      do_ack(2, vec, vcnt);
      chk("ir3_vec", vec, 8'h23);
      wr_reg(2'd2, 8'h00); tick();
      chk("ir3_eoi_isr", isr, 8'h00);

      // AEOI with wrapping vector base, then spurious ack
      wr_reg(2'd3, 8'h01);
      wr_reg(2'd1, 8'hFC);
      pulse(5); tick();
      do_ack(3, vec, vcnt);
      chk("wrap_vec", vec, 8'h01);
      chk("aeoi_isr", isr, 8'h00);
      do_ack(3, vec, vcnt);
      chk("spur_vec", vec, 8'h03);

      // Long ack captures once; IR4 stays pending
      pulse(1); pulse(4); tick();
      do_ack(8, vec, vcnt);
      chk("long_vec", vec, 8'hFD);
      chk("long_valid_cycles", vcnt, 7);
      rd_reg(2'd2, rd);
      chk("long_irr", rd, 8'h10);
      do_ack(2, vec, vcnt);
      chk("ir4_wrap_vec", vec, 8'h00);

      // Reset in the middle of an acknowledge
      pulse(6); tick();
      bif.int_ack = 1'b1;
      tick(); tick();
      chk("midack_valid", bif.vec_valid, 1'b1);
      reset = 1'b1;
      #1;
      chk("midack_rst_valid", bif.vec_valid, 1'b0);
      chk("midack_rst_vec", bif.int_vec, 8'h00);
      bif.int_ack = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
      tick();
      model_step();

      // Randomized traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         irq_in      = 8'($urandom) & 8'($urandom) & 8'($urandom);
         bif.int_ack = bif.int_ack ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0);
         bif.wr      = ($urandom_range(0, 5) == 0);
         bif.cs      = bif.wr;
         bif.addr    = 2'($urandom_range(0, 3));
         bif.din     = 8'($urandom);
         if (bif.addr == 2'd0) bif.din = bif.din & 8'($urandom);
         #1;
         case (bif.addr)
            2'd0:    exp_dout = m_imr;
            2'd1:    exp_dout = m_vbase;
            2'd2:    exp_dout = m_irr;
            default: exp_dout = m_isr;
         endcase
         chk("rnd_dout", bif.dout, exp_dout);
         model_step();
         tick();
         chk("rnd_int_rq", bif.int_rq, m_rq);
         chk("rnd_valid", bif.vec_valid, m_arm && bif.int_ack);
         if (m_arm && bif.int_ack) chk("rnd_vec", bif.int_vec, m_vec);
         chk("rnd_isr", isr, m_isr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
